// File: rtl/parking_defs.sv
// Shared defaults and FSM encoding for the parking slot allocator.
package parking_defs;

    localparam int unsigned NUM_SLOTS_DEF   = 8;
    localparam int unsigned SLOT_W_DEF      = 3;
    localparam int unsigned CNT_W_DEF       = 4;
    localparam int unsigned GATE_CYCLES_DEF = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StGate = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/lowest_free_encoder.sv
// Combinational priority encoder: index of the lowest set bit of a free bitmap.
module lowest_free_encoder #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned SLOT_W    = 3
) (
    input  logic [NUM_SLOTS-1:0] i_bitmap,
    output logic [SLOT_W-1:0]    o_idx,
    output logic                 o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (i_bitmap[i] && !o_found) begin
                o_idx   = SLOT_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_slot_allocator.sv
// Owns the lot's free-slot bitmap: allocates the lowest free slot on entry,
// times the entry gate, and frees slots on exit.
module parking_slot_allocator
    import parking_defs::*;
#(
    parameter int unsigned NUM_SLOTS   = NUM_SLOTS_DEF,
    parameter int unsigned SLOT_W      = SLOT_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic [NUM_SLOTS-1:0] parking_capacity,
    output logic [CNT_W-1:0]     free_count,
    output logic                 full,
    output logic                 entry_ack,
    output logic                 entry_granted,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 gate_open,
    output logic                 exit_error
);

    localparam int unsigned     TMR_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

    alloc_state_e         r_state, w_state_d;
    logic [NUM_SLOTS-1:0] r_cap, w_cap_d;
    logic [CNT_W-1:0]     r_count, w_count_d;
    logic [TMR_W-1:0]     r_timer, w_timer_d;
    logic                 r_ack, w_ack_d;
    logic                 r_granted, w_granted_d;
    logic [SLOT_W-1:0]    r_slot, w_slot_d;
    logic                 r_gate, w_gate_d;
    logic                 r_err, w_err_d;

    logic [SLOT_W-1:0]    w_free_idx;
    logic                 w_free_found;
    logic                 w_exit_in_range;

    // Allocation always decides from the registered bitmap.
    lowest_free_encoder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_lowest_free (
        .i_bitmap (r_cap),
        .o_idx    (w_free_idx),
        .o_found  (w_free_found)
    );

    assign w_exit_in_range = (32'(exit_slot) < NUM_SLOTS);

    always_comb begin
        w_state_d   = r_state;
        w_cap_d     = r_cap;
        w_timer_d   = r_timer;
        w_ack_d     = 1'b0;
        w_granted_d = 1'b0;
        w_slot_d    = r_slot;
        w_gate_d    = 1'b0;
        w_err_d     = 1'b0;

        // Exit only sets bits that are clear in r_cap and allocation only clears bits
        // that are set, so the two updates never touch the same bit.
        if (exit_req) begin
            if (w_exit_in_range && !r_cap[exit_slot]) begin
                w_cap_d[exit_slot] = 1'b1;
            end else begin
                w_err_d = 1'b1;
            end
        end

        unique case (r_state)
            StIdle: begin
                // The ack cycle never samples entry_req, so a held request is not
                // allocated twice.
                if (entry_req && !r_ack) begin
                    w_ack_d = 1'b1;
                    if (w_free_found) begin
                        w_cap_d[w_free_idx] = 1'b0;
                        w_granted_d         = 1'b1;
                        w_slot_d            = w_free_idx;
                        w_gate_d            = 1'b1;
                        w_timer_d           = TMR_LOAD;
                        w_state_d           = StGate;
                    end
                end
            end
            StGate: begin
                if (r_timer == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer - TMR_W'(1);
                    w_gate_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_count_d = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            w_count_d = w_count_d + CNT_W'(w_cap_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cap     <= '1;
            r_count   <= CNT_W'(NUM_SLOTS);
            r_timer   <= '0;
            r_ack     <= 1'b0;
            r_granted <= 1'b0;
            r_slot    <= '0;
            r_gate    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cap     <= w_cap_d;
            r_count   <= w_count_d;
            r_timer   <= w_timer_d;
            r_ack     <= w_ack_d;
            r_granted <= w_granted_d;
            r_slot    <= w_slot_d;
            r_gate    <= w_gate_d;
            r_err     <= w_err_d;
        end
    end

    assign parking_capacity = r_cap;
    assign free_count       = r_count;
    assign full             = (r_count == '0);
    assign entry_ack        = r_ack;
    assign entry_granted    = r_granted;
    assign assigned_slot    = r_slot;
    assign gate_open        = r_gate;
    assign exit_error       = r_err;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Directed self-checking bench for parking_slot_allocator (8 slots, 4-cycle gate).
module tb_parking_slot_allocator;

    logic       clk;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       full;
    logic       entry_ack;
    logic       entry_granted;
    logic [2:0] assigned_slot;
    logic       gate_open;
    logic       exit_error;

    int checks = 0;
    int errors = 0;

    parking_slot_allocator #(
        .NUM_SLOTS   (8),
        .SLOT_W      (3),
        .CNT_W       (4),
        .GATE_CYCLES (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .entry_req        (entry_req),
        .exit_req         (exit_req),
        .exit_slot        (exit_slot),
        .parking_capacity (parking_capacity),
        .free_count       (free_count),
        .full             (full),
        .entry_ack        (entry_ack),
        .entry_granted    (entry_granted),
        .assigned_slot    (assigned_slot),
        .gate_open        (gate_open),
        .exit_error       (exit_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] cap, input logic [3:0] cnt,
                             input logic fl);
        chk({tag, " cap"}, 32'(parking_capacity), 32'(cap));
        chk({tag, " count"}, 32'(free_count), 32'(cnt));
        chk({tag, " full"}, 32'(full), 32'(fl));
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] slot);
        chk({tag, " ack"}, 32'(entry_ack), 32'd1);
        chk({tag, " granted"}, 32'(entry_granted), 32'd1);
        chk({tag, " slot"}, 32'(assigned_slot), 32'(slot));
        chk({tag, " gate"}, 32'(gate_open), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = 3'd0;
        step();
        step();

        // Reset state
        chk_state("reset", 8'hFF, 4'd8, 1'b0);
        chk("reset gate", 32'(gate_open), 32'd0);
        chk("reset ack", 32'(entry_ack), 32'd0);
        chk("reset granted", 32'(entry_granted), 32'd0);
        chk("reset slot", 32'(assigned_slot), 32'd0);
        chk("reset err", 32'(exit_error), 32'd0);

        // Request held from reset: first grant is slot 0; request ignored during GATE
        entry_req = 1'b1;
        rst_n     = 1'b1;
        step();
        chk_grant("grant0", 3'd0);
        chk_state("grant0", 8'hFE, 4'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("grant0 gate held", 32'(gate_open), 32'd1);
            chk("grant0 ack pulse", 32'(entry_ack), 32'd0);
            chk("grant0 cap held", 32'(parking_capacity), 32'hFE);
        end
        step();
        chk("grant0 gate closed", 32'(gate_open), 32'd0);
        chk("grant0 no realloc", 32'(parking_capacity), 32'hFE);
        step();
        chk_grant("grant1", 3'd1);
        chk_state("grant1", 8'hFC, 4'd6, 1'b0);
        entry_req = 1'b0;
        repeat (4) step();
        chk("grant1 gate closed", 32'(gate_open), 32'd0);

        // Fill remaining slots 2..7
        for (int s = 2; s < 8; s++) begin
            entry_req = 1'b1;
            step();
            chk_grant("fill", 3'(s));
            entry_req = 1'b0;
            repeat (4) step();
        end
        chk_state("filled", 8'h00, 4'd0, 1'b1);

        // Full lot: held request is rejected, retried every two cycles
        entry_req = 1'b1;
        step();
        chk("full ack", 32'(entry_ack), 32'd1);
        chk("full granted", 32'(entry_granted), 32'd0);
        chk("full gate", 32'(gate_open), 32'd0);
        chk_state("full reject", 8'h00, 4'd0, 1'b1);
        step();
        chk("full ack gap", 32'(entry_ack), 32'd0);
        step();
        chk("full retry ack", 32'(entry_ack), 32'd1);
        chk("full retry granted", 32'(entry_granted), 32'd0);
        step();

        // Full lot with same-cycle exit of slot 5: entry rejected, exit applied
        exit_req  = 1'b1;
        exit_slot = 3'd5;
        step();
        chk("full+exit ack", 32'(entry_ack), 32'd1);
        chk("full+exit granted", 32'(entry_granted), 32'd0);
        chk("full+exit err", 32'(exit_error), 32'd0);
        chk_state("full+exit", 8'h20, 4'd1, 1'b0);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        step();
        entry_req = 1'b1;
        step();
        chk_grant("regrant5", 3'd5);
        chk_state("regrant5", 8'h00, 4'd0, 1'b1);
        entry_req = 1'b0;
        repeat (4) step();

        // Double exits raise exit_error on the second one
        exit_req  = 1'b1;
        exit_slot = 3'd7;
        step();
        chk("exit7 err", 32'(exit_error), 32'd0);
        chk_state("exit7", 8'h80, 4'd1, 1'b0);
        step();
        chk("exit7 again err", 32'(exit_error), 32'd1);
        chk("exit7 again cap", 32'(parking_capacity), 32'h80);
        exit_slot = 3'd2;
        step();
        chk("exit2 err", 32'(exit_error), 32'd0);
        chk_state("exit2", 8'h84, 4'd2, 1'b0);
        step();
        chk("exit2 again err", 32'(exit_error), 32'd1);
        chk("exit2 again cap", 32'(parking_capacity), 32'h84);
        exit_req = 1'b0;
        step();
        chk("err pulse ends", 32'(exit_error), 32'd0);

        // Allocation plus exit of a different slot in the same cycle
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 3'd0;
        step();
        chk_grant("alloc+exit", 3'd2);
        chk("alloc+exit err", 32'(exit_error), 32'd0);
        chk_state("alloc+exit", 8'h81, 4'd2, 1'b0);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        step();
        chk("pre-reset gate", 32'(gate_open), 32'd1);

        // Reset during GATE aborts the gate and frees every slot
        rst_n = 1'b0;
        step();
        chk("midreset gate", 32'(gate_open), 32'd0);
        chk("midreset slot", 32'(assigned_slot), 32'd0);
        chk_state("midreset", 8'hFF, 4'd8, 1'b0);
        rst_n = 1'b1;
        step();
        chk("after reset gate", 32'(gate_open), 32'd0);

        // Exit naming the slot being allocated: error, allocation still proceeds
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 3'd0;
        step();
        chk_grant("alloc=exit", 3'd0);
        chk("alloc=exit err", 32'(exit_error), 32'd1);
        chk_state("alloc=exit", 8'hFE, 4'd7, 1'b0);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        repeat (4) step();
        chk("final gate", 32'(gate_open), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
